// File: rtl/truth_table_checker_if.sv
// Signal bundle between the exhaustive truth-table checker and the agent that
// launches runs, supplies the function output and reads back the results.
interface truth_table_checker_if #(
  parameter int N = 3
);
  logic         start;
  logic [N-1:0] stim;
  logic         dut_y;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   err_count;
  logic         fail_valid;
  logic [N-1:0] first_fail;

  modport master (
    output start, dut_y,
    input  stim, busy, done, pass, err_count, fail_valid, first_fail
  );

  modport slave (
    input  start, dut_y,
    output stim, busy, done, pass, err_count, fail_valid, first_fail
  );
endinterface

// File: rtl/truth_table_checker.sv
// Exhaustive stimulus sequencer: walks all 2^N input vectors, samples the
// function output after a settle window and scores it against EXPECT.
module truth_table_checker #(
  parameter int                  N      = 3,
  parameter logic [(1<<N)-1:0]   EXPECT = 8'b0011_0001,
  parameter int                  SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  truth_table_checker_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [3:0]   SETTLE_L = 4'(SETTLE);
  localparam logic [N-1:0] V_LAST   = {N{1'b1}};
  localparam logic [N-1:0] V_ONE    = 1;
  localparam logic [N:0]   E_ONE    = 1;

  state_e       state_q, state_d;
  logic [N-1:0] v_q, v_d;
  logic [3:0]   w_q, w_d;
  logic [N-1:0] stim_q, stim_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         pass_q, pass_d;
  logic [N:0]   err_q, err_d;
  logic         fv_q, fv_d;
  logic [N-1:0] ff_q, ff_d;

  logic         mismatch;
  logic [N:0]   err_next;

  always_comb begin
    state_d  = state_q;
    v_d      = v_q;
    w_d      = w_q;
    stim_d   = stim_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fv_d     = fv_q;
    ff_d     = ff_q;
    mismatch = 1'b0;
    err_next = err_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          v_d     = '0;
          w_d     = '0;
          stim_d  = '0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          fv_d    = 1'b0;
          ff_d    = '0;
        end
      end

      RUN: begin
        if (w_q != SETTLE_L) begin
          w_d = w_q + 4'd1;
        end else begin
          // Sample edge: score the vector that has been held for SETTLE+1 cycles.
          mismatch = (bus.dut_y != EXPECT[v_q]);
          if (mismatch) begin
            err_next = err_q + E_ONE;
            err_d    = err_next;
            if (!fv_q) begin
              fv_d = 1'b1;
              ff_d = v_q;
            end
          end
          if (v_q != V_LAST) begin
            v_d    = v_q + V_ONE;
            stim_d = v_q + V_ONE;
            w_d    = '0;
          end else begin
            // The run finishes here; stim keeps the last vector until next start.
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_next == '0);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      v_q     <= '0;
      w_q     <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      w_q     <= w_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
    end
  end

  assign bus.stim       = stim_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fv_q;
  assign bus.first_fail = ff_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: the function under check is the expected
// table XOR a per-vector fault mask, so each run's outcome follows from the mask.
module tb_truth_table_checker;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  truth_table_checker_if #(.N(3)) bus ();
  truth_table_checker_if #(.N(3)) bus0 ();

  logic [7:0] exp_tt = 8'b0011_0001;
  logic [7:0] mask;
  logic [7:0] mask0;

  assign bus.dut_y  = exp_tt[bus.stim] ^ mask[bus.stim];
  assign bus0.dut_y = exp_tt[bus0.stim] ^ mask0[bus0.stim];

  truth_table_checker #(.N(3), .EXPECT(8'b0011_0001), .SETTLE(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  truth_table_checker #(.N(3), .EXPECT(8'b0011_0001), .SETTLE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: mismatches among the first nvec vectors are the set mask bits.
  function automatic int ref_err(input logic [7:0] m, input int nvec);
    int c = 0;
    for (int i = 0; i < nvec && i < 8; i++) c += int'(m[i]);
    return c;
  endfunction

  function automatic int ref_first(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".stim"},       int'(bus.stim), 0);
    chk({tag, ".busy"},       int'(bus.busy), 0);
    chk({tag, ".done"},       int'(bus.done), 0);
    chk({tag, ".pass"},       int'(bus.pass), 0);
    chk({tag, ".err_count"},  int'(bus.err_count), 0);
    chk({tag, ".fail_valid"}, int'(bus.fail_valid), 0);
    chk({tag, ".first_fail"}, int'(bus.first_fail), 0);
  endtask

  task automatic run_main(input logic [7:0] m, input int e_err, input int e_first,
                          input int e_fv, input int e_pass, input string tag);
    int edges;
    int bad;
    mask = m;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    edges = 0;
    bad   = 0;
    while (bus.done !== 1'b1 && edges < 200) begin
      if (bus.stim !== 3'(edges / 3)) bad++;
      if (bus.busy !== 1'b1) bad++;
      if (bus.err_count !== 4'(ref_err(m, edges / 3))) bad++;
      @(posedge clk); #1; edges++;
    end
    chk({tag, ".latency"},    edges, 24);
    chk({tag, ".midrun"},     bad, 0);
    chk({tag, ".busy_end"},   int'(bus.busy), 0);
    chk({tag, ".stim_end"},   int'(bus.stim), 7);
    chk({tag, ".err_count"},  int'(bus.err_count), e_err);
    chk({tag, ".fail_valid"}, int'(bus.fail_valid), e_fv);
    if (e_fv != 0) chk({tag, ".first_fail"}, int'(bus.first_fail), e_first);
    chk({tag, ".pass"},       int'(bus.pass), e_pass);
    @(posedge clk); #1;
    chk({tag, ".done_fall"},  int'(bus.done), 0);
    chk({tag, ".pass_hold"},  int'(bus.pass), e_pass);
    chk({tag, ".stim_hold"},  int'(bus.stim), 7);
  endtask

  typedef struct {
    logic [7:0] m;
    int         err;
    int         first;
    int         fv;
    int         pass;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int edges;
    int bad;
    int seen_done;
    logic [7:0] rm;

    vecs[0] = '{m: 8'h00, err: 0, first: 0, fv: 0, pass: 1};  // matching model
    vecs[1] = '{m: 8'h31, err: 3, first: 0, fv: 1, pass: 0};  // stuck at 0
    vecs[2] = '{m: 8'hCE, err: 5, first: 1, fv: 1, pass: 0};  // stuck at 1
    vecs[3] = '{m: 8'hFF, err: 8, first: 0, fv: 1, pass: 0};  // inverted

    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus0.start = 1'b0;
    mask  = 8'h00;
    mask0 = 8'h00;
    #12;
    chk_reset_vals("reset");
    chk("reset.dut0_busy", int'(bus0.busy), 0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle.busy", int'(bus.busy), 0);

    foreach (vecs[i])
      run_main(vecs[i].m, vecs[i].err, vecs[i].first, vecs[i].fv, vecs[i].pass,
               $sformatf("vec%0d", i));

    for (int k = 0; k < 8; k++) begin
      rm = 8'($urandom);
      run_main(rm, ref_err(rm, 8), ref_first(rm), int'(rm != 8'h00), int'(rm == 8'h00),
               $sformatf("rand%0d_m%02h", k, rm));
    end

    // start held high: back-to-back runs, done for one cycle between them
    mask = 8'h00;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1;
    edges = 0;
    while (bus.done !== 1'b1 && edges < 200) begin
      @(posedge clk); #1; edges++;
    end
    chk("held.first_latency", edges, 24);
    chk("held.first_pass", int'(bus.pass), 1);
    @(posedge clk); #1;
    chk("held.done_fall", int'(bus.done), 0);
    chk("held.busy_relaunch", int'(bus.busy), 1);
    chk("held.pass_cleared", int'(bus.pass), 0);
    chk("held.stim_restart", int'(bus.stim), 0);
    mask = 8'h30;
    edges = 0;
    while (bus.done !== 1'b1 && edges < 200) begin
      bus.start = (edges == 2 || edges == 7 || edges == 13) ? 1'b1 : 1'b0;
      @(posedge clk); #1; edges++;
    end
    bus.start = 1'b0;
    chk("held.second_latency", edges, 24);
    chk("held.second_err", int'(bus.err_count), 2);
    chk("held.second_first", int'(bus.first_fail), 4);
    chk("held.second_pass", int'(bus.pass), 0);
    @(posedge clk); #1;
    chk("held.stays_idle", int'(bus.busy), 0);

    // asynchronous reset in the middle of a run
    mask = 8'h31;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    chk("midrun.err_before_reset", int'(bus.err_count), 1);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    seen_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen_done++;
    end
    @(negedge clk); reset_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen_done++;
    end
    chk("async_reset.no_done", seen_done, 0);
    run_main(8'h00, 0, 0, 0, 1, "post_reset");

    // zero settle time: one vector per cycle
    mask0 = 8'h00;
    @(negedge clk); bus0.start = 1'b1;
    @(posedge clk); #1; bus0.start = 1'b0;
    edges = 0;
    bad   = 0;
    while (bus0.done !== 1'b1 && edges < 100) begin
      if (bus0.stim !== 3'(edges)) bad++;
      @(posedge clk); #1; edges++;
    end
    chk("settle0.latency", edges, 8);
    chk("settle0.stim_steps", bad, 0);
    chk("settle0.pass", int'(bus0.pass), 1);

    mask0 = 8'h81;
    @(negedge clk); bus0.start = 1'b1;
    @(posedge clk); #1; bus0.start = 1'b0;
    edges = 0;
    while (bus0.done !== 1'b1 && edges < 100) begin
      @(posedge clk); #1; edges++;
    end
    chk("settle0.err_latency", edges, 8);
    chk("settle0.err_count", int'(bus0.err_count), 2);
    chk("settle0.first_fail", int'(bus0.first_fail), 0);
    chk("settle0.err_pass", int'(bus0.pass), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Self-checking stimulus sequencer placed directly upstream of a small N-input combinational function block.
- On `start`, it drives every input combination `0 .. 2^N-1` onto the block's inputs.
- It waits a programmable settle time, then samples the block's single output and compares it with an expected truth table held in a parameter.
- It reports the mismatch count, the first failing vector, and an overall pass flag.
- It serves as the on-chip exhaustive checker for 3-input gate-level functions, and as a bench component.

## Interface
Parameters:
- `N`, 3, number of function inputs (1..6).
- `EXPECT`, 8'b0011_0001, expected output. Bit `v` is the expected output for input vector `v`. Width `2^N`.
- `SETTLE`, 2, extra cycles each vector is held before sampling (0..15).

Ports:
- `clk`  in  1  single clock; everything is updated on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset. Assertion takes effect immediately; deassertion is synchronous to `clk` by the system.
- `start`  in  1  level-sampled run request. It is accepted only in IDLE.
- `stim`  out  N  input vector to the function. The MSB is the first function input (`a`), the LSB is the last (`c`).
- `dut_y`  in  1  function output under check.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse when a run completes.
- `pass`  out  1  high when the last completed run had zero mismatches. It is held until the next start.
- `err_count`  out  N+1  number of mismatching vectors in the last or current run.
- `fail_valid`  out  1  high once any mismatch has been recorded in the current or last run.
- `first_fail`  out  N  lowest-index vector that mismatched. It is valid only when `fail_valid` is high.

## Operation
Reset values: `stim`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_valid`=0, `first_fail`=0. State is IDLE and internal counters are 0.

The state machine has three states:
- IDLE:
  - On an edge with `start`=1: go to RUN with vector index `v`=0 and settle counter `w`=0.
  - Also set `stim`=0, `busy`=1, and clear `err_count`, `fail_valid`, `first_fail` and `pass`.
  - With `start`=0: stay in IDLE; all outputs hold.
- RUN: each vector window lasts SETTLE+1 cycles.
  - If `w` < SETTLE: increment `w`.
  - If `w` == SETTLE (the sample edge):
    - Compare `dut_y` against `EXPECT[v]`.
    - On mismatch, increment `err_count`.
    - If the mismatch is the first of the run, set `fail_valid`=1 and `first_fail`=`v`.
    - If `v` < 2^N-1: set `v`=`v`+1, `stim`=`v`+1 and `w`=0.
    - Otherwise go to FIN.
- FIN: never occupies a cycle of its own. The transition from the last sample edge goes directly to IDLE with `done`=1, `busy`=0, and `pass`=(final `err_count`==0). `done` clears on the following edge.

Further rules:
- `start` is ignored while `busy`=1.
- `stim` holds the last applied vector (2^N-1) after completion until the next start.
- `err_count` cannot overflow: its maximum value 2^N fits in N+1 bits.
- The sample on the last vector's sample edge is included in the final `err_count` and `pass`.
- Reset mid-run aborts the run immediately: all outputs take their reset values and no `done` pulse is produced.
- `start` is sampled in the cycle in which `done`=1. If it is high, a new run launches on that edge: the `done` pulse lasts one cycle and `busy` rises on the same edge.

## Timing
- `stim` changes only on edges. The first vector appears one edge after `start` is sampled.
- Sampling point: `dut_y` is sampled SETTLE+1 edges after the corresponding `stim` change.
- Per-vector latency is SETTLE+1 cycles. Total run time is T = 2^N·(SETTLE+1) cycles.
- Counting the start-accept edge as edge 0, `done` rises on edge T and falls on edge T+1.
- `err_count`, `fail_valid` and `first_fail` update on sample edges and are observable mid-run.
- `pass` updates only on edge T.
- Defaults give T=24.

## Test plan
- Matching function model (output 1 for vectors 0, 4, 5) with defaults, `start` pulse at edge 0:
  - `stim` steps 0..7, changing every 3 cycles.
  - `done` is high for exactly one cycle, after edge 24.
  - `pass`=1, `err_count`=0, `fail_valid`=0.
- `dut_y` stuck at 0:
  - `err_count`=3, `first_fail`=0, `fail_valid`=1, `pass`=0.
- `dut_y` stuck at 1:
  - `err_count`=5, `first_fail`=1, `pass`=0.
- Inverted model output:
  - `err_count`=8, `first_fail`=0.
- `start` held high continuously:
  - First run completes at edge 24.
  - A second run launches on edge 25: `done` lasts one cycle and `busy` is high after edge 25.
  - Results are cleared at edge 25.
  - `start` pulses during a run change nothing.
- Reset and SETTLE variants:
  - `reset_n` low asynchronously at cycle 10: all outputs return to their reset values immediately, and there is no `done`.
  - After reset is released, a new run passes normally.
  - With SETTLE=0: `done` arrives after 8 cycles, with `stim` changing every cycle.
